scr1_dmem_vec_serializer: RTL and testbench

SCR1_DMEM_VEC_SERIALIZER -- requirements
Module: scr1_dmem_vec_serializer

---
 rtl/scr1_vec_pkg.sv | 42 ++++
 rtl/scr1_dmem_vec_serializer.sv | 127 ++++++++++++
 tb/tb_scr1_dmem_vec_serializer.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_vec_pkg.sv
// Shared types for the vector-to-word DMEM serializer: memory interface
// enums, the vector data type and the serializer FSM encoding.
package scr1_vec_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_VEC_LANE    = 16;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE   = 2'b00,
    SCR1_MEM_WIDTH_HWORD  = 2'b01,
    SCR1_MEM_WIDTH_WORD   = 2'b10,
    SCR1_MEM_WIDTH_VECTOR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    VEC_IDLE = 2'b00,
    VEC_REQ  = 2'b01,
    VEC_WAIT = 2'b10,
    VEC_DONE = 2'b11
  } vec_state_e;

  typedef logic [SCR1_VEC_LANE-1:0][31:0] type_vector;

  // A single-lane build still needs a one-bit beat counter.
  function automatic int scr1_vec_beat_w(input int lane);
    return (lane > 1) ? $clog2(lane) : 1;
  endfunction

  localparam int SCR1_VEC_BEAT_W = scr1_vec_beat_w(SCR1_VEC_LANE);

endpackage

// File: rtl/scr1_dmem_vec_serializer.sv
// Splits a core-side vector (or scalar) access into 32-bit memory beats and
// reassembles load data into a LANE x 32 buffer.
module scr1_dmem_vec_serializer
  import scr1_vec_pkg::*;
#(
  parameter int LANE = SCR1_VEC_LANE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          lsu2dmem_req,
  input  type_scr1_mem_cmd_e            lsu2dmem_cmd,
  input  type_scr1_mem_width_e          lsu2dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0]   lsu2dmem_addr,
  input  logic [LANE-1:0][31:0]         lsu2dmem_wdata,
  output logic                          dmem2lsu_req_ack,
  output logic [LANE-1:0][31:0]         dmem2lsu_rdata,
  output type_scr1_mem_resp_e           dmem2lsu_resp,
  output logic                          mem_req,
  output type_scr1_mem_cmd_e            mem_cmd,
  output type_scr1_mem_width_e          mem_width,
  output logic [SCR1_DMEM_AWIDTH-1:0]   mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic                          mem_req_ack,
  input  logic [31:0]                   mem_rdata,
  input  type_scr1_mem_resp_e           mem_resp
);

  localparam int BEAT_W = scr1_vec_beat_w(LANE);

  vec_state_e                  state_q, state_d;
  type_scr1_mem_cmd_e          cmd_q, cmd_d;
  type_scr1_mem_width_e        width_q, width_d;
  logic [SCR1_DMEM_AWIDTH-1:0] addr_q, addr_d;
  logic [LANE-1:0][31:0]       wdata_q, wdata_d;
  logic [LANE-1:0][31:0]       buf_q, buf_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [BEAT_W-1:0]           last_q, last_d;
  logic                        err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= VEC_IDLE;
      cmd_q   <= SCR1_MEM_CMD_RD;
      width_q <= SCR1_MEM_WIDTH_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      beat_q  <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      width_q <= width_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    width_d = width_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    beat_d  = beat_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      VEC_IDLE: begin
        if (lsu2dmem_req) begin
          cmd_d   = lsu2dmem_cmd;
          width_d = lsu2dmem_width;
          addr_d  = lsu2dmem_addr;
          wdata_d = lsu2dmem_wdata;
          buf_d   = '0;
          beat_d  = '0;
          last_d  = (lsu2dmem_width == SCR1_MEM_WIDTH_VECTOR) ? BEAT_W'(LANE - 1) : '0;
          err_d   = 1'b0;
          state_d = VEC_REQ;
        end
      end
      VEC_REQ: begin
        if (mem_req_ack) state_d = VEC_WAIT;
      end
      VEC_WAIT: begin
        if (mem_resp == SCR1_MEM_RESP_RDY_OK) begin
          // Stores never touch the buffer so their response data stays zero.
          if (cmd_q == SCR1_MEM_CMD_RD) buf_d[beat_q] = mem_rdata;
          if (beat_q == last_q) begin
            state_d = VEC_DONE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = VEC_REQ;
          end
        end else if (mem_resp == SCR1_MEM_RESP_RDY_ER) begin
          err_d   = 1'b1;
          state_d = VEC_DONE;
        end
      end
      VEC_DONE: begin
        state_d = VEC_IDLE;
      end
      default: begin
        state_d = VEC_IDLE;
      end
    endcase
  end

  assign dmem2lsu_req_ack = (state_q == VEC_IDLE);
  assign dmem2lsu_rdata   = buf_q;
  assign dmem2lsu_resp    = (state_q != VEC_DONE) ? SCR1_MEM_RESP_NOTRDY
                          : (err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK);

  // Every beat of a vector is a plain word access; address wraps naturally.
  assign mem_req   = (state_q == VEC_REQ);
  assign mem_cmd   = cmd_q;
  assign mem_width = (width_q == SCR1_MEM_WIDTH_VECTOR) ? SCR1_MEM_WIDTH_WORD : width_q;
  assign mem_addr  = addr_q + {{(SCR1_DMEM_AWIDTH-BEAT_W-2){1'b0}}, beat_q, 2'b00};
  assign mem_wdata = wdata_q[beat_q];

endmodule

// File: tb/tb_scr1_dmem_vec_serializer.sv
// Directed bench for scr1_dmem_vec_serializer: scalar table plus vector,
// stall, error, back-to-back, spurious-response and mid-burst reset sequences.
module tb_scr1_dmem_vec_serializer;
  import scr1_vec_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        lsu2dmem_req;
  type_scr1_mem_cmd_e          lsu2dmem_cmd;
  type_scr1_mem_width_e        lsu2dmem_width;
  logic [SCR1_DMEM_AWIDTH-1:0] lsu2dmem_addr;
  type_vector                  lsu2dmem_wdata;
  logic                        dmem2lsu_req_ack;
  type_vector                  dmem2lsu_rdata;
  type_scr1_mem_resp_e         dmem2lsu_resp;
  logic                        mem_req;
  type_scr1_mem_cmd_e          mem_cmd;
  type_scr1_mem_width_e        mem_width;
  logic [SCR1_DMEM_AWIDTH-1:0] mem_addr;
  logic [31:0]                 mem_wdata;
  logic                        mem_req_ack;
  logic [31:0]                 mem_rdata;
  type_scr1_mem_resp_e         mem_resp;

  scr1_dmem_vec_serializer #(.LANE(SCR1_VEC_LANE)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu2dmem_req(lsu2dmem_req), .lsu2dmem_cmd(lsu2dmem_cmd),
    .lsu2dmem_width(lsu2dmem_width), .lsu2dmem_addr(lsu2dmem_addr),
    .lsu2dmem_wdata(lsu2dmem_wdata), .dmem2lsu_req_ack(dmem2lsu_req_ack),
    .dmem2lsu_rdata(dmem2lsu_rdata), .dmem2lsu_resp(dmem2lsu_resp),
    .mem_req(mem_req), .mem_cmd(mem_cmd), .mem_width(mem_width),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req_ack(mem_req_ack),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- memory model (driven on negedge) ----------------
  int                   ack_delay   = 0;
  int                   err_idx     = -1;
  bit                   spurious_en = 1'b0;
  int                   ack_total   = 0;
  bit                   unstable    = 1'b0;
  bit                   pend        = 1'b0;
  int                   stall       = 0;
  int                   p_idx;
  type_scr1_mem_cmd_e   p_cmd;
  logic [31:0]          p_addr, p_wdata, s_addr, s_wdata;
  logic [31:0]          log_addr [0:255];
  logic [31:0]          log_data [0:255];
  type_scr1_mem_width_e log_w    [0:255];
  logic [31:0]          wr_mem   [int];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (wr_mem.exists(int'(a >> 2))) return wr_mem[int'(a >> 2)];
    if (a[31:2] == 30'h40) return 32'hDEADBEEF;
    return 32'h1000_0000 | {a[31:2], 2'b00};
  endfunction

  always @(negedge clk) begin
    mem_req_ack = 1'b0;
    mem_resp    = SCR1_MEM_RESP_NOTRDY;
    mem_rdata   = 32'h0;
    if (!rst_n) begin
      pend  = 1'b0;
      stall = 0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        if (p_idx == err_idx) begin
          mem_resp = SCR1_MEM_RESP_RDY_ER;
        end else begin
          mem_resp = SCR1_MEM_RESP_RDY_OK;
          if (p_cmd == SCR1_MEM_CMD_WR) wr_mem[int'(p_addr >> 2)] = p_wdata;
          else mem_rdata = rd_word(p_addr);
        end
      end else if (spurious_en) begin
        mem_resp  = SCR1_MEM_RESP_RDY_OK;
        mem_rdata = 32'hBAD0BAD0;
      end
      if (mem_req) begin
        if (stall == 0) begin
          s_addr  = mem_addr;
          s_wdata = mem_wdata;
        end else if (mem_addr !== s_addr || mem_wdata !== s_wdata) begin
          unstable = 1'b1;
        end
        if (stall < ack_delay) begin
          stall++;
        end else begin
          stall       = 0;
          mem_req_ack = 1'b1;
          pend        = 1'b1;
          p_idx       = ack_total;
          p_cmd       = mem_cmd;
          p_addr      = mem_addr;
          p_wdata     = mem_wdata;
          log_addr[ack_total[7:0]] = mem_addr;
          log_data[ack_total[7:0]] = mem_wdata;
          log_w[ack_total[7:0]]    = mem_width;
          ack_total++;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_xfer(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                          input logic [31:0] a, input type_vector wd,
                          output int lat, output type_scr1_mem_resp_e r,
                          output type_vector rd, output int first);
    @(negedge clk);
    lsu2dmem_req   = 1'b1;
    lsu2dmem_cmd   = c;
    lsu2dmem_width = w;
    lsu2dmem_addr  = a;
    lsu2dmem_wdata = wd;
    first          = ack_total;
    @(posedge clk);
    @(negedge clk);
    lsu2dmem_req = 1'b0;
    lat = 1;
    while (dmem2lsu_resp == SCR1_MEM_RESP_NOTRDY && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    r  = dmem2lsu_resp;
    rd = dmem2lsu_rdata;
    @(negedge clk);
    chk("resp_one_cycle", 32'(dmem2lsu_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("ack_after_done", 32'(dmem2lsu_req_ack), 32'd1);
  endtask

  typedef struct {
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e width;
    logic [31:0]          addr;
    logic [31:0]          wd0;
    logic [31:0]          exp_rdata;
    int                   exp_lat;
  } rec_t;

  rec_t                tbl [7];
  type_vector          wd, rd;
  type_scr1_mem_resp_e r;
  int                  lat, first, n;
  logic [31:0]         hi_or;

  initial begin
    tbl[0] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h100, 32'h0,        32'hDEADBEEF, 3};
    tbl[1] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE,  32'h101, 32'h0,        32'hDEADBEEF, 3};
    tbl[2] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD,  32'h104, 32'h12345678, 32'h0,        3};
    tbl[3] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h104, 32'h0,        32'h12345678, 3};
    tbl[4] = '{SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE,  32'h10B, 32'h000000A5, 32'h0,        3};
    tbl[5] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h108, 32'h0,        32'h000000A5, 3};
    tbl[6] = '{SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD,  32'h3FC, 32'h0,        32'h100003FC, 3};

    lsu2dmem_req   = 1'b0;
    lsu2dmem_cmd   = SCR1_MEM_CMD_RD;
    lsu2dmem_width = SCR1_MEM_WIDTH_WORD;
    lsu2dmem_addr  = '0;
    lsu2dmem_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ack", 32'(dmem2lsu_req_ack), 32'd1);
    chk("rst_resp",    32'(dmem2lsu_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rdata",   dmem2lsu_rdata[0] | dmem2lsu_rdata[15], 32'd0);
    rst_n = 1'b1;

    // scalar table
    for (int i = 0; i < 7; i++) begin
      wd    = '0;
      wd[0] = tbl[i].wd0;
      run_xfer(tbl[i].cmd, tbl[i].width, tbl[i].addr, wd, lat, r, rd, first);
      chk($sformatf("t%0d_lat", i),   32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("t%0d_resp", i),  32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
      chk($sformatf("t%0d_rdata", i), rd[0], tbl[i].exp_rdata);
      hi_or = '0;
      for (int k = 1; k < 16; k++) hi_or |= rd[k];
      chk($sformatf("t%0d_hi_zero", i), hi_or, 32'h0);
      chk($sformatf("t%0d_beats", i), 32'(ack_total - first), 32'd1);
      chk($sformatf("t%0d_addr", i),  log_addr[first[7:0]], tbl[i].addr);
      chk($sformatf("t%0d_width", i), 32'(log_w[first[7:0]]), 32'(tbl[i].width));
      chk($sformatf("t%0d_wdata", i), log_data[first[7:0]], tbl[i].wd0);
    end

    // vector store: 16 word beats, lane k = k*0x11
    for (int k = 0; k < 16; k++) wd[k] = 32'(k) * 32'h11;
    run_xfer(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_VECTOR, 32'h200, wd, lat, r, rd, first);
    chk("sv_lat", 32'(lat), 32'd33);
    chk("sv_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("sv_beats", 32'(ack_total - first), 32'd16);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("sv_addr%0d", k), log_addr[8'(first + k)], 32'h200 + 32'(4 * k));
      chk($sformatf("sv_data%0d", k), log_data[8'(first + k)], 32'(k) * 32'h11);
      chk($sformatf("sv_width%0d", k), 32'(log_w[8'(first + k)]), 32'(SCR1_MEM_WIDTH_WORD));
    end
    hi_or = '0;
    for (int k = 0; k < 16; k++) hi_or |= rd[k];
    chk("sv_rdata_zero", hi_or, 32'h0);

    // vector load with two stall cycles per beat
    ack_delay = 2;
    run_xfer(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h400, '0, lat, r, rd, first);
    ack_delay = 0;
    chk("lv_stall_lat", 32'(lat), 32'd65);
    chk("lv_stall_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("lv_stall_beats", 32'(ack_total - first), 32'd16);
    chk("lv_stall_stable", 32'(unstable), 32'd0);
    for (int k = 0; k < 16; k++)
      chk($sformatf("lv_lane%0d", k), rd[k], 32'h1000_0400 + 32'(4 * k));

    // vector load failing on beat 5
    err_idx = ack_total + 5;
    run_xfer(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h400, '0, lat, r, rd, first);
    err_idx = -1;
    chk("lv_err_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_ER));
    chk("lv_err_lat", 32'(lat), 32'd13);
    chk("lv_err_beats", 32'(ack_total - first), 32'd6);
    for (int k = 0; k < 16; k++)
      chk($sformatf("lv_err_lane%0d", k), rd[k], (k < 5) ? 32'h1000_0400 + 32'(4 * k) : 32'h0);

    // address wrap across 2^32
    for (int k = 0; k < 16; k++) wd[k] = 32'hC000_0000 + 32'(k);
    run_xfer(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_VECTOR, 32'hFFFF_FFF0, wd, lat, r, rd, first);
    chk("wrap_addr3", log_addr[8'(first + 3)], 32'hFFFF_FFFC);
    chk("wrap_addr4", log_addr[8'(first + 4)], 32'h0000_0000);
    chk("wrap_data4", log_data[8'(first + 4)], 32'hC000_0004);

    // spurious memory response while idle
    @(negedge clk);
    spurious_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("spur_ack", 32'(dmem2lsu_req_ack), 32'd1);
      chk("spur_resp", 32'(dmem2lsu_resp), 32'(SCR1_MEM_RESP_NOTRDY));
      chk("spur_mem_req", 32'(mem_req), 32'd0);
      chk("spur_rdata", dmem2lsu_rdata[0], 32'h0);
    end
    spurious_en = 1'b0;

    // request raised during DONE must wait for IDLE
    @(negedge clk);
    lsu2dmem_req   = 1'b1;
    lsu2dmem_cmd   = SCR1_MEM_CMD_RD;
    lsu2dmem_width = SCR1_MEM_WIDTH_WORD;
    lsu2dmem_addr  = 32'h100;
    lsu2dmem_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    lsu2dmem_req = 1'b0;
    n = 0;
    while (dmem2lsu_resp == SCR1_MEM_RESP_NOTRDY && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done", 32'(dmem2lsu_resp), 32'(SCR1_MEM_RESP_RDY_OK));
    lsu2dmem_req  = 1'b1;
    lsu2dmem_addr = 32'h104;
    chk("b2b_no_ack_in_done", 32'(dmem2lsu_req_ack), 32'd0);
    @(negedge clk);
    chk("b2b_idle_ack", 32'(dmem2lsu_req_ack), 32'd1);
    chk("b2b_idle_resp", 32'(dmem2lsu_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    @(posedge clk);
    @(negedge clk);
    lsu2dmem_req = 1'b0;
    chk("b2b_mem_req", 32'(mem_req), 32'd1);
    chk("b2b_mem_addr", mem_addr, 32'h104);
    lat = 1;
    while (dmem2lsu_resp == SCR1_MEM_RESP_NOTRDY && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_lat", 32'(lat), 32'd3);
    chk("b2b_rdata", dmem2lsu_rdata[0], 32'h12345678);

    // reset asserted during beat 7 of a vector store
    @(negedge clk);
    for (int k = 0; k < 16; k++) wd[k] = 32'(k) * 32'h11;
    lsu2dmem_req   = 1'b1;
    lsu2dmem_cmd   = SCR1_MEM_CMD_WR;
    lsu2dmem_width = SCR1_MEM_WIDTH_VECTOR;
    lsu2dmem_addr  = 32'h200;
    lsu2dmem_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    lsu2dmem_req = 1'b0;
    n = 0;
    while (!(mem_req && mem_addr == 32'h21C) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_found_beat7", 32'(n < 200), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_resp", 32'(dmem2lsu_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    chk("rst_mid_ack", 32'(dmem2lsu_req_ack), 32'd1);
    @(negedge clk);
    chk("rst_mid_no_resp", 32'(dmem2lsu_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_still_idle", 32'(mem_req), 32'd0);
    run_xfer(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, '0, lat, r, rd, first);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_resp", 32'(r), 32'(SCR1_MEM_RESP_RDY_OK));
    chk("post_rst_rdata", rd[0], 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
